// File: rtl/synth_cfg_pkg.sv
// Shared cfg-register map for the synth core: word bases, field offsets and the
// small types used by every block that writes cfg words.
package synth_cfg_pkg;

  localparam int CFG_WORDS           = 8;
  localparam int CEIL_LOG2_CFG_WORDS = 3;

  localparam int OSC_PERIOD_BASE = 0;
  localparam int MOD_PERIOD_BASE = 2;

  // Period/octave word layout: low 12 bits period, high 4 bits octave.
  localparam int PERIOD_LSB = 0;
  localparam int PERIOD_MSB = 11;
  localparam int OCTAVE_LSB = 12;
  localparam int OCTAVE_MSB = 15;

  typedef logic [1:0] byte_en_t;

  localparam byte_en_t BE_NONE = 2'b00;
  localparam byte_en_t BE_ALL  = 2'b11;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  function automatic logic [15:0] pack_period_word(input logic [3:0] octave,
                                                   input logic [11:0] period);
    logic [15:0] word;
    word = 16'h0000;
    word[OCTAVE_MSB:OCTAVE_LSB] = octave;
    word[PERIOD_MSB:PERIOD_LSB] = period;
    return word;
  endfunction

endpackage

// File: rtl/cfg_step_sequencer_tempo_divider.sv
// Reloadable down-counter: tick is high while enabled at count zero, and the
// counter reloads on that tick or on an explicit load.
module tempo_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tick
);

  logic [W-1:0] count_r;

  assign tick = en & (count_r == {W{1'b0}});

  // Down-counter with priority load, reload on tick, hold when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (tick) begin
      count_r <= load_value;
    end else if (en) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/cfg_step_sequencer.sv
// Owns the cfg write port: arbitrates host writes against a tempo-driven step
// sequencer that rewrites one cfg word from a small programmable step memory.
module cfg_step_sequencer #(
  parameter int LOG2_STEPS          = 3,
  parameter int TEMPO_BITS          = 16,
  parameter int CEIL_LOG2_CFG_WORDS = synth_cfg_pkg::CEIL_LOG2_CFG_WORDS,
  parameter int TARGET_WORD         = synth_cfg_pkg::OSC_PERIOD_BASE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           host_req,
  input  logic [CEIL_LOG2_CFG_WORDS-1:0] host_addr,
  input  logic [1:0]                     host_be,
  input  logic [15:0]                    host_data,
  output logic                           host_ack,
  input  logic                           prog_we,
  input  logic [LOG2_STEPS-1:0]          prog_addr,
  input  logic [15:0]                    prog_data,
  input  logic                           run,
  input  logic [TEMPO_BITS-1:0]          tempo,
  input  logic [LOG2_STEPS-1:0]          last_step,
  output logic [1:0]                     cfg_we,
  output logic [CEIL_LOG2_CFG_WORDS-1:0] cfg_w_addr,
  output logic [15:0]                    cfg_w_data,
  output logic [LOG2_STEPS-1:0]          step_index,
  output logic                           overrun
);
  import synth_cfg_pkg::*;

  localparam int NUM_STEPS = 1 << LOG2_STEPS;
  localparam logic [CEIL_LOG2_CFG_WORDS-1:0] TARGET_ADDR = CEIL_LOG2_CFG_WORDS'(TARGET_WORD);

  seq_state_e state_r;
  seq_state_e state_next_s;
  logic       start_s;
  logic       seq_en_s;
  logic       stop_s;
  logic       div_tick_s;
  logic       tick_s;
  logic       host_grant_s;
  logic       seq_grant_s;

  logic                  pending_r;
  logic [15:0]           pend_data_r;
  logic                  overrun_r;
  logic [LOG2_STEPS-1:0] step_index_r;
  logic [LOG2_STEPS-1:0] step_index_next_s;
  logic [LOG2_STEPS-1:0] tick_idx_s;
  logic [15:0]           step_rd_s;
  logic [15:0]           mem_r [NUM_STEPS];

  byte_en_t                       cfg_we_r;
  logic [CEIL_LOG2_CFG_WORDS-1:0] cfg_w_addr_r;
  logic [15:0]                    cfg_w_data_r;
  logic                           host_ack_r;

  // Sequencer state register (remembers run from the previous cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: follow the run level.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SEQ_IDLE: if (run) state_next_s = SEQ_RUN;  else state_next_s = SEQ_IDLE;
      SEQ_RUN:  if (run) state_next_s = SEQ_RUN;  else state_next_s = SEQ_IDLE;
      default:  state_next_s = SEQ_IDLE;
    endcase
  end

  // State decode: start forces a step-0 tick, stop discards the pending write.
  always_comb begin
    start_s  = 1'b0;
    seq_en_s = 1'b0;
    stop_s   = 1'b0;
    case (state_r)
      SEQ_IDLE: start_s = run;
      SEQ_RUN: begin
        seq_en_s = run;
        stop_s   = ~run;
      end
      default: begin
        start_s  = 1'b0;
        seq_en_s = 1'b0;
        stop_s   = 1'b0;
      end
    endcase
  end

  tempo_divider #(.W(TEMPO_BITS)) u_tempo (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (seq_en_s),
    .load       (start_s),
    .load_value (tempo),
    .tick       (div_tick_s)
  );

  assign tick_s       = start_s | div_tick_s;
  assign host_grant_s = host_req & ~host_ack_r;
  assign seq_grant_s  = pending_r & run & ~host_grant_s;
  assign tick_idx_s   = start_s ? {LOG2_STEPS{1'b0}} : step_index_r;
  assign step_rd_s    = mem_r[tick_idx_s];

  // Step index advance; past last_step it simply wraps at the memory depth.
  always_comb begin
    step_index_next_s = step_index_r;
    if (start_s) begin
      if (last_step == {LOG2_STEPS{1'b0}}) step_index_next_s = {LOG2_STEPS{1'b0}};
      else                                 step_index_next_s = LOG2_STEPS'(1);
    end else if (div_tick_s) begin
      if (step_index_r == last_step) step_index_next_s = {LOG2_STEPS{1'b0}};
      else                           step_index_next_s = step_index_r + LOG2_STEPS'(1);
    end else begin
      step_index_next_s = step_index_r;
    end
  end

  // Step memory; a tick reading the index being written sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STEPS; i++) mem_r[i] <= 16'h0000;
    end else if (prog_we) begin
      mem_r[prog_addr] <= prog_data;
    end else begin
      mem_r[prog_addr] <= mem_r[prog_addr];
    end
  end

  // Pending sequencer write; a new tick overrides the grant's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r    <= 1'b0;
      pend_data_r  <= 16'h0000;
      overrun_r    <= 1'b0;
      step_index_r <= {LOG2_STEPS{1'b0}};
    end else begin
      overrun_r    <= tick_s & pending_r & ~seq_grant_s;
      step_index_r <= step_index_next_s;
      if (stop_s) begin
        pending_r <= 1'b0;
      end else if (tick_s) begin
        pending_r   <= 1'b1;
        pend_data_r <= step_rd_s;
      end else if (seq_grant_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Registered cfg write port; host has priority, addr/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_we_r     <= BE_NONE;
      cfg_w_addr_r <= {CEIL_LOG2_CFG_WORDS{1'b0}};
      cfg_w_data_r <= 16'h0000;
      host_ack_r   <= 1'b0;
    end else begin
      host_ack_r <= host_grant_s;
      if (host_grant_s) begin
        cfg_we_r     <= host_be;
        cfg_w_addr_r <= host_addr;
        cfg_w_data_r <= host_data;
      end else if (seq_grant_s) begin
        cfg_we_r     <= BE_ALL;
        cfg_w_addr_r <= TARGET_ADDR;
        cfg_w_data_r <= pend_data_r;
      end else begin
        cfg_we_r <= BE_NONE;
      end
    end
  end

  assign cfg_we     = cfg_we_r;
  assign cfg_w_addr = cfg_w_addr_r;
  assign cfg_w_data = cfg_w_data_r;
  assign host_ack   = host_ack_r;
  assign step_index = step_index_r;
  assign overrun    = overrun_r;

endmodule
